pokey_audio_mixer: RTL and testbench

//  Parametrised N-channel audio mixer/bus-register block that replaces the fixed two-POKEY zero-gain sum.

---
 rtl/pokey_audio_mixer_if.sv | 12 +
 rtl/pokey_audio_mixer.sv | 133 +++++++++++++
 tb/tb_pokey_audio_mixer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pokey_audio_mixer_if.sv
// CPU I/O bus seen by the POKEY audio mixer: chip select, direction, address,
// write data and registered read data.
interface pokey_audio_mixer_if;
  logic       cs_n;
  logic       rw_n;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs_n, output rw_n, output addr, output din, input dout);
  modport slave  (input cs_n, input rw_n, input addr, input din, output dout);
endinterface

// File: rtl/pokey_audio_mixer.sv
// N-channel gain/sum mixer for the POKEY sound outputs with saturation to OW bits,
// plus CPU-visible gain, control and sticky status registers.
module pokey_audio_mixer #(
  parameter int unsigned NCH = 2,
  parameter int unsigned SW  = 6,
  parameter int unsigned GW  = 4,
  parameter int unsigned OW  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce2Hd,
  pokey_audio_mixer_if.slave  bus,
  input  logic [NCH*SW-1:0]   snd_in,
  output logic [OW-1:0]       sout,
  output logic                sout_valid,
  output logic                busy
);

  localparam int unsigned AW = SW + GW + $clog2(NCH + 1);
  localparam int unsigned IW = $clog2(NCH + 1);
  localparam logic [GW-1:0] GAIN_UNITY = GW'(1 << (GW - 1));
  localparam logic [IW-1:0] IDX_LAST   = IW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [AW-1:0] acc;
  logic [AW-1:0] res;
  logic          sat;
  logic [SW-1:0] snap  [NCH];
  logic [GW-1:0] gsnap [NCH];
  logic [GW-1:0] gain  [NCH];
  logic          mute, clip, ovr;
  logic          wr_en, rd_en;
  logic [7:0]    rd_data;
  logic          unused_din;

  assign wr_en      = !bus.cs_n && !bus.rw_n;
  assign rd_en      = !bus.cs_n &&  bus.rw_n;
  assign res        = acc >> (GW - 1);
  assign sat        = (res >> OW) != '0;
  assign unused_din = ^bus.din;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ce2Hd) state_nxt = ACC;
      ACC:     if (idx == IDX_LAST) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshots shift down one channel per ACC clock so the MAC always reads entry 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      idx        <= '0;
      busy       <= 1'b0;
      sout       <= '0;
      sout_valid <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        snap[k]  <= '0;
        gsnap[k] <= '0;
      end
    end else begin
      sout_valid <= 1'b0;
      case (state)
        IDLE: if (ce2Hd) begin
          for (int unsigned k = 0; k < NCH; k++) begin
            snap[k]  <= snd_in[k*SW +: SW];
            gsnap[k] <= gain[k];
          end
          acc  <= '0;
          idx  <= '0;
          busy <= 1'b1;
        end
        ACC: begin
          acc <= acc + AW'(snap[0]) * AW'(gsnap[0]);
          idx <= idx + 1'b1;
          for (int unsigned k = 0; k + 1 < NCH; k++) begin
            snap[k]  <= snap[k+1];
            gsnap[k] <= gsnap[k+1];
          end
        end
        OUT: begin
          sout       <= mute ? '0 : (sat ? '1 : OW'(res));
          sout_valid <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NCH; k++)
      if (bus.addr == 4'(k)) rd_data = 8'(gain[k]);
    if (bus.addr == 4'hF) rd_data = {5'b0, ovr, clip, mute};
  end

  // Sticky sets come after the ctrl clears so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NCH; k++) gain[k] <= GAIN_UNITY;
      mute     <= 1'b0;
      clip     <= 1'b0;
      ovr      <= 1'b0;
      bus.dout <= '0;
    end else begin
      if (wr_en) begin
        for (int unsigned k = 0; k < NCH; k++)
          if (bus.addr == 4'(k)) gain[k] <= bus.din[GW-1:0];
        if (bus.addr == 4'hF) begin
          mute <= bus.din[0];
          if (bus.din[1]) clip <= 1'b0;
          if (bus.din[2]) ovr  <= 1'b0;
        end
      end
      if (ce2Hd && state != IDLE)        ovr  <= 1'b1;
      if (state == OUT && !mute && sat)  clip <= 1'b1;
      if (rd_en) bus.dout <= rd_data;
    end
  end

endmodule

// File: tb/tb_pokey_audio_mixer.sv
// Directed bench for pokey_audio_mixer: a default OW=8 instance and an OW=7 instance
// share stimulus; a vector table covers the mix function, hand sequences cover timing corners.
module tb_pokey_audio_mixer;

  logic        clk;
  logic        reset_n;
  logic        ce2Hd;
  logic [11:0] snd_in;
  logic [7:0]  sout;
  logic [6:0]  sout7;
  logic        sout_valid, sout_valid7;
  logic        busy, busy7;

  int checks = 0;
  int errors = 0;

  pokey_audio_mixer_if bus ();
  pokey_audio_mixer_if bus7 ();

  pokey_audio_mixer #(.NCH(2), .SW(6), .GW(4), .OW(8)) dut (
    .clk(clk), .reset_n(reset_n), .ce2Hd(ce2Hd), .bus(bus), .snd_in(snd_in),
    .sout(sout), .sout_valid(sout_valid), .busy(busy)
  );

  pokey_audio_mixer #(.NCH(2), .SW(6), .GW(4), .OW(7)) dut7 (
    .clk(clk), .reset_n(reset_n), .ce2Hd(ce2Hd), .bus(bus7), .snd_in(snd_in),
    .sout(sout7), .sout_valid(sout_valid7), .busy(busy7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] g0, g1;
    logic [5:0] s0, s1;
    logic       mute;
    logic [7:0] exp8;
    logic [6:0] exp7;
    logic [7:0] st7;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic bus_set(input logic cs_n, input logic rw_n, input logic [3:0] a, input logic [7:0] d);
    bus.cs_n = cs_n;  bus.rw_n = rw_n;  bus.addr = a;  bus.din = d;
    bus7.cs_n = cs_n; bus7.rw_n = rw_n; bus7.addr = a; bus7.din = d;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus_set(1'b0, 1'b0, a, d);
    tick();
    bus_set(1'b1, 1'b1, 4'h0, 8'h00);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d8, output logic [7:0] d7);
    bus_set(1'b0, 1'b1, a, 8'h00);
    tick();
    d8 = bus.dout;
    d7 = bus7.dout;
    bus_set(1'b1, 1'b1, 4'h0, 8'h00);
  endtask

  // Pulse ce2Hd for one clock, then wait (bounded) for sout_valid.
  task automatic run_mix(input logic [5:0] s0, input logic [5:0] s1, output int lat, output int bcnt);
    snd_in = {s1, s0};
    ce2Hd = 1'b1;
    tick();
    ce2Hd = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!sout_valid && lat < 10) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    logic [7:0] d8, d7;
    int lat, bcnt, vcnt;

    vecs[0] = '{4'd8,  4'd8,  6'd63, 6'd63, 1'b0, 8'd126, 7'd126, 8'h00};
    vecs[1] = '{4'd15, 4'd0,  6'd40, 6'd63, 1'b0, 8'd75,  7'd75,  8'h00};
    vecs[2] = '{4'd15, 4'd15, 6'd63, 6'd63, 1'b0, 8'd236, 7'd127, 8'h02};
    vecs[3] = '{4'd1,  4'd2,  6'd7,  6'd5,  1'b0, 8'd2,   7'd2,   8'h00};
    vecs[4] = '{4'd8,  4'd8,  6'd0,  6'd0,  1'b0, 8'd0,   7'd0,   8'h00};
    vecs[5] = '{4'd15, 4'd15, 6'd63, 6'd63, 1'b1, 8'd0,   7'd0,   8'h01};
    vecs[6] = '{4'd3,  4'd5,  6'd33, 6'd20, 1'b0, 8'd24,  7'd24,  8'h00};
    vecs[7] = '{4'd9,  4'd7,  6'd50, 6'd60, 1'b0, 8'd108, 7'd108, 8'h00};
    vecs[8] = '{4'd12, 4'd12, 6'd45, 6'd45, 1'b0, 8'd135, 7'd127, 8'h02};

    reset_n = 1'b0;
    ce2Hd = 1'b0;
    snd_in = '0;
    bus_set(1'b1, 1'b1, 4'h0, 8'h00);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    check("reset_sout", int'(sout), 0);
    check("reset_valid", int'(sout_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_dout", int'(bus.dout), 0);
    rd(4'd0, d8, d7);  check("reset_gain0", int'(d8), 8);
    rd(4'd1, d8, d7);  check("reset_gain1", int'(d8), 8);
    rd(4'd15, d8, d7); check("reset_status", int'(d8), 0);
    tick();
    check("dout_hold", int'(bus.dout), 0);

    // Default gains, full-scale inputs: latency, busy width, single valid pulse.
    run_mix(6'd63, 6'd63, lat, bcnt);
    check("t1_latency", lat, 3);
    check("t1_busy_clks", bcnt, 3);
    check("t1_sout", int'(sout), 126);
    check("t1_busy_low", int'(busy), 0);
    tick();
    check("t1_valid_width", int'(sout_valid), 0);
    check("t1_sout_hold", int'(sout), 126);

    wr(4'd5, 8'hFF);
    rd(4'd5, d8, d7);  check("unmapped_read", int'(d8), 0);
    rd(4'd0, d8, d7);  check("unmapped_write", int'(d8), 8);

    for (int i = 0; i < 9; i++) begin
      wr(4'd0, {4'h0, vecs[i].g0});
      wr(4'd1, {4'h0, vecs[i].g1});
      wr(4'd15, {5'b0, 1'b1, 1'b1, vecs[i].mute});
      run_mix(vecs[i].s0, vecs[i].s1, lat, bcnt);
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_sout8", i), int'(sout), int'(vecs[i].exp8));
      check($sformatf("vec%0d_sout7", i), int'(sout7), int'(vecs[i].exp7));
      check($sformatf("vec%0d_valid7", i), int'(sout_valid7), 1);
      rd(4'd15, d8, d7);
      check($sformatf("vec%0d_status8", i), int'(d8), int'({7'b0, vecs[i].mute}));
      check($sformatf("vec%0d_status7", i), int'(d7), int'(vecs[i].st7));
    end

    // Clip clear in the OUT cycle loses to the clip set.
    wr(4'd15, 8'h06);
    wr(4'd0, 8'h0F);
    wr(4'd1, 8'h0F);
    snd_in = {6'd63, 6'd63};
    ce2Hd = 1'b1; tick(); ce2Hd = 1'b0;
    tick(); tick();
    bus_set(1'b0, 1'b0, 4'hF, 8'h02);
    tick();
    bus_set(1'b1, 1'b1, 4'h0, 8'h00);
    check("clip_set_wins_valid", int'(sout_valid7), 1);
    rd(4'd15, d8, d7); check("clip_set_wins", int'(d7), 8'h02);
    wr(4'd15, 8'h02);
    rd(4'd15, d8, d7); check("clip_cleared", int'(d7), 0);

    // Second tick while busy is dropped, sets ovr; input change mid-mix ignored.
    wr(4'd0, 8'h08);
    wr(4'd1, 8'h08);
    snd_in = {6'd20, 6'd10};
    ce2Hd = 1'b1; tick();
    tick();
    ce2Hd = 1'b0;
    snd_in = '0;
    vcnt = 0;
    for (int n = 0; n < 10; n++) begin
      if (sout_valid) begin
        vcnt++;
        check("t4_sout", int'(sout), 30);
      end
      tick();
    end
    check("t4_valid_count", vcnt, 1);
    rd(4'd15, d8, d7); check("t4_ovr", int'(d8), 8'h04);
    wr(4'd15, 8'h04);
    rd(4'd15, d8, d7); check("t4_ovr_cleared", int'(d8), 0);

    // ovr set and ovr clear on the same edge: set wins.
    snd_in = {6'd20, 6'd10};
    ce2Hd = 1'b1; tick();
    bus_set(1'b0, 1'b0, 4'hF, 8'h04);
    tick();
    ce2Hd = 1'b0;
    bus_set(1'b1, 1'b1, 4'h0, 8'h00);
    tick(); tick(); tick();
    rd(4'd15, d8, d7); check("ovr_set_wins", int'(d8), 8'h04);
    wr(4'd15, 8'h06);

    // Gain write mid-mix applies to the following mix only.
    snd_in = {6'd40, 6'd40};
    ce2Hd = 1'b1; tick(); ce2Hd = 1'b0;
    wr(4'd0, 8'h0F);
    lat = 0;
    while (!sout_valid && lat < 10) begin tick(); lat++; end
    check("t5_latency", lat, 2);
    check("t5_old_gain", int'(sout), 80);
    tick();
    run_mix(6'd40, 6'd40, lat, bcnt);
    check("t5_new_gain", int'(sout), 115);

    // Reset during ACC aborts the mix and restores defaults.
    tick();
    snd_in = {6'd63, 6'd63};
    ce2Hd = 1'b1; tick(); ce2Hd = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("t6_sout", int'(sout), 0);
    check("t6_busy", int'(busy), 0);
    tick();
    reset_n = 1'b1;
    vcnt = 0;
    for (int n = 0; n < 5; n++) begin
      if (sout_valid) vcnt++;
      tick();
    end
    check("t6_no_valid", vcnt, 0);
    rd(4'd0, d8, d7); check("t6_gain0", int'(d8), 8);
    rd(4'd1, d8, d7); check("t6_gain1", int'(d8), 8);
    run_mix(6'd63, 6'd63, lat, bcnt);
    check("t6_next_latency", lat, 3);
    check("t6_next_sout", int'(sout), 126);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
